// File: rtl/reg_file_param_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param_if
// Brief    : Read/write/reserve bus of the parametrised register file.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   rd_addr1;
  logic [DATA_W-1:0]   rd_data1;
  logic                busy1;
  logic [ADDR_W-1:0]   rd_addr2;
  logic [DATA_W-1:0]   rd_data2;
  logic                busy2;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_be;
  logic                rsv_en;
  logic [ADDR_W-1:0]   rsv_addr;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr,
    input  rd_data1, busy1, rd_data2, busy2
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr,
    output rd_data1, busy1, rd_data2, busy2
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param
// Brief    : 2R/1W register file with byte enables, optional zero register,
//            optional write-to-read bypass and a per-register pending scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  reg_file_param_if.slave bus
);
  localparam int              c_BE_W  = DATA_W / 8;
  localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic [DEPTH-1:0]  w_wr_sel;
  logic [DEPTH-1:0]  w_rsv_sel;
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_wr_merged;
  logic [DATA_W-1:0] w_rd_raw1;
  logic [DATA_W-1:0] w_rd_raw2;
  logic              w_pend1;
  logic              w_pend2;
  logic              w_byp1;
  logic              w_byp2;
  logic              w_rsv_hit1;
  logic              w_rsv_hit2;

  // Qualifying with reset keeps bypass and busy quiet while reset is held.
  assign w_wr_ok  = reset && bus.wr_en && ({1'b0, bus.wr_addr} < c_DEPTH) &&
                    !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign w_rsv_ok = reset && bus.rsv_en && ({1'b0, bus.rsv_addr} < c_DEPTH) &&
                    !((ZERO_REG != 0) && (bus.rsv_addr == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_sel
    assign w_wr_sel[i]  = w_wr_ok  && (bus.wr_addr  == ADDR_W'(i));
    assign w_rsv_sel[i] = w_rsv_ok && (bus.rsv_addr == ADDR_W'(i));
  end

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    w_rd_raw1 = '0;
    w_rd_raw2 = '0;
    w_wr_old  = '0;
    w_pend1   = 1'b0;
    w_pend2   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_addr1 == ADDR_W'(i)) begin
        w_rd_raw1 = r_mem[i];
        w_pend1   = r_pend[i];
      end
      if (bus.rd_addr2 == ADDR_W'(i)) begin
        w_rd_raw2 = r_mem[i];
        w_pend2   = r_pend[i];
      end
      if (bus.wr_addr == ADDR_W'(i)) begin
        w_wr_old = r_mem[i];
      end
    end
  end

  for (genvar b = 0; b < c_BE_W; b++) begin : g_byte
    assign w_wr_merged[8*b +: 8] = bus.wr_be[b] ? bus.wr_data[8*b +: 8]
                                                : w_wr_old[8*b +: 8];
  end

  // Reservation takes priority over a same-cycle write clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_sel[i]) begin
          r_mem[i] <= w_wr_merged;
        end
        if (w_rsv_sel[i]) begin
          r_pend[i] <= 1'b1;
        end else if (w_wr_sel[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  assign w_byp1     = (BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rd_addr1);
  assign w_byp2     = (BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rd_addr2);
  assign w_rsv_hit1 = w_rsv_ok && (bus.rsv_addr == bus.rd_addr1);
  assign w_rsv_hit2 = w_rsv_ok && (bus.rsv_addr == bus.rd_addr2);

  assign bus.rd_data1 = w_byp1 ? w_wr_merged : w_rd_raw1;
  assign bus.rd_data2 = w_byp2 ? w_wr_merged : w_rd_raw2;
  assign bus.busy1    = w_pend1 && !(w_byp1 && !w_rsv_hit1);
  assign bus.busy2    = w_pend2 && !(w_byp2 && !w_rsv_hit2);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_param
// Brief    : Directed and randomised checks of two register-file configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  // a: DEPTH 24, zero register, bypass.  b: DEPTH 32, no zero register, no bypass.
  reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  assign bus_b.rd_addr1 = bus_a.rd_addr1;
  assign bus_b.rd_addr2 = bus_a.rd_addr2;
  assign bus_b.wr_en    = bus_a.wr_en;
  assign bus_b.wr_addr  = bus_a.wr_addr;
  assign bus_b.wr_data  = bus_a.wr_data;
  assign bus_b.wr_be    = bus_a.wr_be;
  assign bus_b.rsv_en   = bus_a.rsv_en;
  assign bus_b.rsv_addr = bus_a.rsv_addr;

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .ZERO_REG(1), .BYPASS(1))
    u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  reg_file_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(0), .BYPASS(0))
    u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  logic [31:0] m_mem  [2][32];
  logic        m_pend [2][32];

  function automatic int cfg_depth(int k); return (k == 0) ? 24 : 32; endfunction
  function automatic bit cfg_zero(int k);  return k == 0; endfunction
  function automatic bit cfg_byp(int k);   return k == 0; endfunction

  function automatic bit addr_ok(int k, logic [4:0] a);
    return (int'(a) < cfg_depth(k)) && !(cfg_zero(k) && a == 5'd0);
  endfunction

  function automatic bit wr_valid(int k);
    return reset && bus_a.wr_en && addr_ok(k, bus_a.wr_addr);
  endfunction

  function automatic bit rsv_valid(int k);
    return reset && bus_a.rsv_en && addr_ok(k, bus_a.rsv_addr);
  endfunction

  function automatic logic [31:0] merged(int k);
    logic [31:0] v;
    v = m_mem[k][bus_a.wr_addr];
    for (int b = 0; b < 4; b++)
      if (bus_a.wr_be[b]) v[8*b +: 8] = bus_a.wr_data[8*b +: 8];
    return v;
  endfunction

  function automatic logic [31:0] exp_data(int k, logic [4:0] a);
    if (!addr_ok(k, a)) return 32'd0;
    if (cfg_byp(k) && wr_valid(k) && bus_a.wr_addr == a) return merged(k);
    return m_mem[k][a];
  endfunction

  function automatic logic [31:0] exp_busy(int k, logic [4:0] a);
    if (!addr_ok(k, a)) return 32'd0;
    if (cfg_byp(k) && wr_valid(k) && bus_a.wr_addr == a &&
        !(rsv_valid(k) && bus_a.rsv_addr == a)) return 32'd0;
    return {31'd0, m_pend[k][a]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = 32'd0;
        m_pend[k][i] = 1'b0;
      end
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_valid(k)) begin
          m_mem[k][bus_a.wr_addr]  = merged(k);
          m_pend[k][bus_a.wr_addr] = 1'b0;
        end
        if (rsv_valid(k)) m_pend[k][bus_a.rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_all();
    check("a.rd1",   bus_a.rd_data1,        exp_data(0, bus_a.rd_addr1));
    check("a.rd2",   bus_a.rd_data2,        exp_data(0, bus_a.rd_addr2));
    check("a.busy1", {31'd0, bus_a.busy1},  exp_busy(0, bus_a.rd_addr1));
    check("a.busy2", {31'd0, bus_a.busy2},  exp_busy(0, bus_a.rd_addr2));
    check("b.rd1",   bus_b.rd_data1,        exp_data(1, bus_a.rd_addr1));
    check("b.rd2",   bus_b.rd_data2,        exp_data(1, bus_a.rd_addr2));
    check("b.busy1", {31'd0, bus_b.busy1},  exp_busy(1, bus_a.rd_addr1));
    check("b.busy2", {31'd0, bus_b.busy2},  exp_busy(1, bus_a.rd_addr2));
  endtask

  task automatic idle();
    bus_a.wr_en  = 1'b0;
    bus_a.rsv_en = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = a;
    bus_a.wr_data = d;
    bus_a.wr_be   = be;
  endtask

  task automatic rsv(input logic [4:0] a);
    bus_a.rsv_en   = 1'b1;
    bus_a.rsv_addr = a;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    model_reset();
    bus_a.rd_addr1 = 5'd5;
    bus_a.rd_addr2 = 5'd5;
    bus_a.wr_addr  = 5'd0;
    bus_a.wr_data  = 32'd0;
    bus_a.wr_be    = 4'd0;
    bus_a.rsv_addr = 5'd0;
    idle();
    #2;
    check("rst_a_rd1",   bus_a.rd_data1,       32'd0);
    check("rst_b_rd1",   bus_b.rd_data1,       32'd0);
    check("rst_a_busy1", {31'd0, bus_a.busy1}, 32'd0);
    check("rst_b_busy2", {31'd0, bus_b.busy2}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-cycle wipes r5 and swallows the concurrent write.
    wr(5'd5, 32'hDEADBEEF, 4'hF);
    tick();
    idle();
    @(negedge clk);
    check("wr5_a", bus_a.rd_data1, 32'hDEADBEEF);
    check("wr5_b", bus_b.rd_data1, 32'hDEADBEEF);
    wr(5'd5, 32'h12345678, 4'hF);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rstmid_a_rd1",   bus_a.rd_data1,       32'd0);
    check("rstmid_b_rd1",   bus_b.rd_data1,       32'd0);
    check("rstmid_a_busy1", {31'd0, bus_a.busy1}, 32'd0);
    @(posedge clk);
    #2;
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("rsthold_a_rd1", bus_a.rd_data1, 32'd0);
    check("rsthold_b_rd1", bus_b.rd_data1, 32'd0);
    tick();

    // Byte-enable merge, bypassed on a, stored-only on b.
    bus_a.rd_addr2 = 5'd7;
    wr(5'd7, 32'h11223344, 4'hF);
    tick();
    wr(5'd7, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    check("be_byp_a", bus_a.rd_data2, 32'h11BB33DD);
    check("be_byp_b", bus_b.rd_data2, 32'h11223344);
    tick();
    idle();
    @(negedge clk);
    check("be_after_a", bus_a.rd_data2, 32'h11BB33DD);
    check("be_after_b", bus_b.rd_data2, 32'h11BB33DD);
    tick();

    // Zero register and out-of-range address.
    bus_a.rd_addr1 = 5'd0;
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    tick();
    idle();
    @(negedge clk);
    check("zero_a", bus_a.rd_data1, 32'd0);
    check("zero_b", bus_b.rd_data1, 32'hFFFFFFFF);
    tick();
    bus_a.rd_addr1 = 5'd30;
    wr(5'd30, 32'h00000055, 4'hF);
    tick();
    idle();
    @(negedge clk);
    check("range_a", bus_a.rd_data1, 32'd0);
    check("range_b", bus_b.rd_data1, 32'h00000055);
    tick();
    bus_a.rd_addr1 = 5'd0;
    rsv(5'd0);
    tick();
    idle();
    @(negedge clk);
    check("rsv0_a_busy", {31'd0, bus_a.busy1}, 32'd0);
    check("rsv0_b_busy", {31'd0, bus_b.busy1}, 32'd1);
    tick();

    // Scoreboard lifecycle on r9.
    bus_a.rd_addr1 = 5'd9;
    rsv(5'd9);
    @(negedge clk);
    check("rsv9_same_a", {31'd0, bus_a.busy1}, 32'd0);
    check("rsv9_same_b", {31'd0, bus_b.busy1}, 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("rsv9_next_a", {31'd0, bus_a.busy1}, 32'd1);
    check("rsv9_next_b", {31'd0, bus_b.busy1}, 32'd1);
    tick();
    wr(5'd9, 32'h00000099, 4'hF);
    @(negedge clk);
    check("wr9_busy_a", {31'd0, bus_a.busy1}, 32'd0);
    check("wr9_busy_b", {31'd0, bus_b.busy1}, 32'd1);
    check("wr9_data_a", bus_a.rd_data1, 32'h00000099);
    check("wr9_data_b", bus_b.rd_data1, 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("wr9_after_busy_a", {31'd0, bus_a.busy1}, 32'd0);
    check("wr9_after_busy_b", {31'd0, bus_b.busy1}, 32'd0);
    check("wr9_after_data_a", bus_a.rd_data1, 32'h00000099);
    check("wr9_after_data_b", bus_b.rd_data1, 32'h00000099);
    tick();
    rsv(5'd9);
    tick();
    wr(5'd9, 32'h00001234, 4'hF);
    rsv(5'd9);
    @(negedge clk);
    check("both9_busy_a", {31'd0, bus_a.busy1}, 32'd1);
    check("both9_busy_b", {31'd0, bus_b.busy1}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("both9_after_busy_a", {31'd0, bus_a.busy1}, 32'd1);
    check("both9_after_busy_b", {31'd0, bus_b.busy1}, 32'd1);
    check("both9_after_data_a", bus_a.rd_data1, 32'h00001234);
    tick();

    // Randomised dual-port traffic against the reference model.
    for (int n = 0; n < 10000; n++) begin
      bus_a.wr_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        bus_a.rd_addr1 = bus_a.wr_addr;
        bus_a.rd_addr2 = bus_a.wr_addr;
      end else begin
        bus_a.rd_addr1 = 5'($urandom_range(0, 31));
        bus_a.rd_addr2 = 5'($urandom_range(0, 31));
      end
      bus_a.rsv_addr = ($urandom_range(0, 2) == 0) ? bus_a.wr_addr
                                                   : 5'($urandom_range(0, 31));
      bus_a.wr_en    = 1'($urandom_range(0, 1));
      bus_a.rsv_en   = ($urandom_range(0, 3) == 0);
      bus_a.wr_be    = 4'($urandom_range(0, 15));
      bus_a.wr_data  = $urandom;
      @(negedge clk);
      check_all();
      tick();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
